imem_loadable: RTL and testbench

- Parametrised, run-time loadable successor to the fixed instruction ROM for the 9-bit RISC core.
- Holds the program in a writable array that a loader port fills after reset.
- Registers the fetched word (one-cycle fetch latency) and supports stall and flush from the core.
- Returns the halt encoding for any unwritten or out-of-range address; detects halt and freezes fetch until restart.

---
 rtl/imem_pkg.sv | 7 +
 rtl/imem_array.sv | 30 +++
 rtl/imem_loadable.sv | 80 ++++++++
 tb/tb_imem_loadable.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared state encoding and default widths/halt encoding for the loadable instruction memory.
package imem_pkg;
  localparam int INST_W_DEF = 9;
  localparam int PC_W_DEF = 8;
  localparam logic [INST_W_DEF-1:0] HALT_INST_DEF = 9'h1FF;
  typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x INST_W program storage with per-word written flags,
// one write port and a combinational read that substitutes the halt word.
module imem_array #(
  parameter int INST_W = 9,
  parameter int PC_W = 8,
  parameter int DEPTH = 256,
  parameter logic [INST_W-1:0] HALT_INST = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [PC_W-1:0]   waddr_i,
  input  logic [INST_W-1:0] wdata_i,
  input  logic [PC_W-1:0]   raddr_i,
  output logic [INST_W-1:0] rdata_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [INST_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  written_q;
  logic              w_in, r_in;
  assign w_in = int'(waddr_i) < DEPTH;
  assign r_in = int'(raddr_i) < DEPTH;
  // Only the written flags are reset; contents survive so a reload can patch.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) written_q <= '0;
    else if (we_i && w_in) written_q[waddr_i[AW-1:0]] <= 1'b1;
  always_ff @(posedge clk)
    if (we_i && w_in) mem_q[waddr_i[AW-1:0]] <= wdata_i;
  assign rdata_o = (r_in && written_q[raddr_i[AW-1:0]]) ? mem_q[raddr_i[AW-1:0]] : HALT_INST;
endmodule

// File: rtl/imem_loadable.sv
// imem_loadable: run-time loadable instruction memory with registered fetch,
// stall/flush handling, halt detection and a saturating delivered-word counter.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int INST_W = INST_W_DEF,
  parameter int PC_W = PC_W_DEF,
  parameter int DEPTH = 256,
  parameter logic [INST_W-1:0] HALT_INST = INST_W'(HALT_INST_DEF),
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [PC_W-1:0]   load_addr,
  input  logic [INST_W-1:0] load_data,
  input  logic              load_done,
  input  logic              fetch_en,
  input  logic [PC_W-1:0]   pc,
  input  logic              stall,
  input  logic              flush,
  input  logic              restart,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);
  state_t            state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d, rd;
  logic              valid_q, valid_d, consume;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  assign load_ready = state_q == LOAD;
  assign consume = valid_q && !stall && !flush;
  imem_array #(.INST_W(INST_W), .PC_W(PC_W), .DEPTH(DEPTH), .HALT_INST(HALT_INST)) u_array (
    .clk(CLK), .rst_n(rst_n), .we_i(load_valid && load_ready), .waddr_i(load_addr),
    .wdata_i(load_data), .raddr_i(pc), .rdata_o(rd)
  );
  always_comb begin
    state_d = state_q;
    inst_d = inst_q;
    valid_d = valid_q;
    cnt_d = (consume && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      LOAD: if (load_done) begin
        state_d = RUN;
        cnt_d = '0;
      end
      RUN: if (flush) valid_d = 1'b0;
      else if (!stall) begin
        valid_d = fetch_en;
        if (fetch_en) begin
          inst_d = rd;
          state_d = rd == HALT_INST ? HALT : RUN;
        end
      end
      HALT: if (restart) begin
        state_d = LOAD;
        valid_d = 1'b0;
      end else valid_d = valid_q && stall && !flush;
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      state_q <= LOAD;
      inst_q <= HALT_INST;
      valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      inst_q <= inst_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
    end
  assign inst = inst_q;
  assign inst_valid = valid_q;
  assign halted = state_q == HALT;
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: directed self-checking bench for imem_loadable (DEPTH=128 so out-of-range writes can be exercised).
module tb_imem_loadable;
  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0, load_done = 1'b0, fetch_en = 1'b0;
  logic       stall = 1'b0, flush = 1'b0, restart = 1'b0;
  logic [7:0] load_addr = '0, pc = '0;
  logic [8:0] load_data = '0;
  logic       load_ready, inst_valid, halted;
  logic [8:0] inst;
  logic [15:0] fetch_count;
  int errs = 0, checks = 0;

  imem_loadable #(.DEPTH(128)) dut (
    .CLK(CLK), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
    .fetch_en(fetch_en), .pc(pc), .stall(stall), .flush(flush), .restart(restart),
    .inst(inst), .inst_valid(inst_valid), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [8:0] e_inst, input logic e_v,
                         input logic e_h, input logic [15:0] e_cnt);
    chk({tag, ".inst"}, 32'(inst), 32'(e_inst));
    chk({tag, ".valid"}, 32'(inst_valid), 32'(e_v));
    chk({tag, ".halted"}, 32'(halted), 32'(e_h));
    chk({tag, ".count"}, 32'(fetch_count), 32'(e_cnt));
  endtask

  initial begin
    #12;
    chk("reset.ready", 32'(load_ready), 32'd1);
    chk_out("reset", 9'h1FF, 1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;
    tick();
    // initial program
    load_valid = 1'b1; load_addr = 8'd0; load_data = 9'h100;
    tick();
    load_addr = 8'd1; load_data = 9'h039;
    tick();
    load_valid = 1'b0; load_done = 1'b1; fetch_en = 1'b1; pc = 8'd5;
    tick();
    load_done = 1'b0; fetch_en = 1'b0;
    chk("run.ready", 32'(load_ready), 32'd0);
    chk_out("run.entry", 9'h1FF, 1'b0, 1'b0, 16'd0);
    // back-to-back fetches
    fetch_en = 1'b1; pc = 8'd0;
    tick();
    chk_out("fetch0", 9'h100, 1'b1, 1'b0, 16'd0);
    pc = 8'd1;
    tick();
    chk_out("fetch1", 9'h039, 1'b1, 1'b0, 16'd1);
    fetch_en = 1'b0;
    tick();
    chk_out("idle", 9'h039, 1'b0, 1'b0, 16'd2);
    // stall holds word for 3 cycles
    fetch_en = 1'b1; pc = 8'd0;
    tick();
    fetch_en = 1'b0; stall = 1'b1;
    tick();
    tick();
    tick();
    chk_out("stall3", 9'h100, 1'b1, 1'b0, 16'd2);
    stall = 1'b0;
    tick();
    chk_out("stall.release", 9'h100, 1'b0, 1'b0, 16'd3);
    // flush of a delivered word
    fetch_en = 1'b1; pc = 8'd1;
    tick();
    chk_out("pre.flush", 9'h039, 1'b1, 1'b0, 16'd3);
    fetch_en = 1'b0; flush = 1'b1;
    tick();
    chk_out("flush", 9'h039, 1'b0, 1'b0, 16'd3);
    // flush concurrent with halt-returning fetch
    fetch_en = 1'b1; pc = 8'd5;
    tick();
    chk_out("flush.halt", 9'h039, 1'b0, 1'b0, 16'd3);
    flush = 1'b0;
    // unwritten address halts
    tick();
    chk_out("halt", 9'h1FF, 1'b1, 1'b1, 16'd3);
    pc = 8'd0;
    tick();
    chk_out("halt.ignore", 9'h1FF, 1'b0, 1'b1, 16'd4);
    tick();
    chk_out("halt.hold", 9'h1FF, 1'b0, 1'b1, 16'd4);
    // restart and patch
    fetch_en = 1'b0; restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart.ready", 32'(load_ready), 32'd1);
    chk_out("restart", 9'h1FF, 1'b0, 1'b0, 16'd4);
    load_valid = 1'b1; load_addr = 8'd2; load_data = 9'h0A5;
    tick();
    load_addr = 8'hFF; load_data = 9'h055;
    tick();
    load_valid = 1'b0; load_done = 1'b1;
    tick();
    load_done = 1'b0;
    chk_out("reload", 9'h1FF, 1'b0, 1'b0, 16'd0);
    fetch_en = 1'b1; pc = 8'd2;
    tick();
    chk_out("patched", 9'h0A5, 1'b1, 1'b0, 16'd0);
    pc = 8'd0;
    tick();
    chk_out("retained", 9'h100, 1'b1, 1'b0, 16'd1);
    pc = 8'hFF;
    tick();
    chk_out("oor", 9'h1FF, 1'b1, 1'b1, 16'd2);
    fetch_en = 1'b0; stall = 1'b1;
    tick();
    chk_out("halt.stall", 9'h1FF, 1'b1, 1'b1, 16'd2);
    stall = 1'b0;
    tick();
    chk_out("halt.drop", 9'h1FF, 1'b0, 1'b1, 16'd3);
    // async reset mid-run
    restart = 1'b1;
    tick();
    restart = 1'b0; load_done = 1'b1;
    tick();
    load_done = 1'b0; fetch_en = 1'b1; pc = 8'd0;
    tick();
    chk_out("prereset", 9'h100, 1'b1, 1'b0, 16'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("areset.ready", 32'(load_ready), 32'd1);
    chk_out("areset", 9'h1FF, 1'b0, 1'b0, 16'd0);
    tick();
    rst_n = 1'b1; fetch_en = 1'b0; load_done = 1'b1;
    tick();
    load_done = 1'b0; fetch_en = 1'b1; pc = 8'd0;
    tick();
    chk_out("forgotten", 9'h1FF, 1'b1, 1'b1, 16'd0);
    fetch_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
